// File: rtl/seg_pkg.sv
// Shared types, constants and the hex font for the two-digit 7-segment scan driver.
package seg_pkg;

  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} scan_state_t;

  typedef struct packed {
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       en1;
    logic       en0;
  } disp_cfg_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segments, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-segment decoder shared by both digits.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1, with
// digit values latched into a shadow register and made active only at frame start.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       en0,
  input  logic       en1,
  input  logic       load,
  output logic       a0,
  output logic       a1,
  output logic [6:0] cathode,
  output logic       frame_done
);

  localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_LEN);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  if (REFRESH_DIV < 2 || BLANK_CYCLES < 1) begin : g_param_check
    $error("seven_seg_scan_driver: REFRESH_DIV must be >=2 and BLANK_CYCLES >=1");
  end

  scan_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  disp_cfg_t shadow, shadow_nxt, active, active_nxt, load_cfg;
  logic at_end, lit0, lit1;
  logic [3:0] dec_hex;
  logic [6:0] dec_seg;

  seg_hex_decoder u_dec (
    .hex (dec_hex),
    .seg (dec_seg)
  );

  // Outputs are computed from next-state values so they change on the same edge as state.
  always_comb begin
    at_end = (state == SHOW0 || state == SHOW1) ? (cnt == SHOW_LAST) : (cnt == BLANK_LAST);
    cnt_nxt = at_end ? '0 : cnt + CW'(1);
    state_nxt = state;
    if (at_end) begin
      case (state)
        BLANK0:  state_nxt = SHOW0;
        SHOW0:   state_nxt = BLANK1;
        BLANK1:  state_nxt = SHOW1;
        default: state_nxt = BLANK0;
      endcase
    end
    load_cfg   = {digit1, digit0, en1, en0};
    shadow_nxt = load ? load_cfg : shadow;
    active_nxt = (at_end && state == SHOW1) ? shadow_nxt : active;
    lit0       = (state_nxt == SHOW0) && active_nxt.en0;
    lit1       = (state_nxt == SHOW1) && active_nxt.en1;
    dec_hex    = (state_nxt == SHOW1) ? active_nxt.digit1 : active_nxt.digit0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= BLANK0;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      a0         <= 1'b1;
      a1         <= 1'b1;
      cathode    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      active     <= active_nxt;
      a0         <= !lit0;
      a1         <= !lit1;
      cathode    <= (lit0 || lit1) ? dec_seg : SEG_OFF;
      frame_done <= (state_nxt == SHOW1) && (cnt_nxt == SHOW_LAST);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2 (20-cycle frame).
module tb_seven_seg_scan_driver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] digit0, digit1;
  logic       en0, en1, load;
  logic       a0, a1, frame_done;
  logic [6:0] cathode;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] d0;
    logic [3:0] d1;
    logic       e0;
    logic       e1;
    int         load_pos;
    logic [6:0] c0;
    logic [6:0] c1;
  } vec_t;

  vec_t vecs[9];
  vec_t none, cur, va, vb;

  seven_seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .digit0     (digit0),
    .digit1     (digit1),
    .en0        (en0),
    .en1        (en1),
    .load       (load),
    .a0         (a0),
    .a1         (a1),
    .cathode    (cathode),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int p, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s pos=%0d got=%h want=%h", name, p, act, exp);
    end
  endtask

  // Frame position p: 0-1 BLANK0, 2-9 SHOW0, 10-11 BLANK1, 12-19 SHOW1.
  task automatic check_pos(input int p, input vec_t e);
    logic s0, s1;
    logic [6:0] ec;
    s0 = (p >= 2 && p <= 9) && e.e0;
    s1 = (p >= 12 && p <= 19) && e.e1;
    ec = s0 ? e.c0 : (s1 ? e.c1 : 7'h7F);
    chk("a0", p, {6'b0, a0}, {6'b0, !s0});
    chk("a1", p, {6'b0, a1}, {6'b0, !s1});
    chk("cathode", p, cathode, ec);
    chk("frame_done", p, {6'b0, frame_done}, {6'b0, p == 19});
  endtask

  task automatic drive(input vec_t v);
    digit0 = v.d0;
    digit1 = v.d1;
    en0    = v.e0;
    en1    = v.e1;
    load   = 1'b1;
  endtask

  // Checks positions 0..n_pos-1 of a frame against e; loads va/vb during positions pa/pb.
  task automatic run_frame(input vec_t e, input int n_pos, input int pa, input vec_t la,
                           input int pb, input vec_t lb);
    for (int p = 0; p < n_pos; p++) begin
      check_pos(p, e);
      if (p == pa) drive(la);
      else if (p == pb) drive(lb);
      @(posedge clock);
      @(negedge clock);
      load = 1'b0;
    end
  endtask

  initial begin
    none    = '{4'h0, 4'h0, 1'b0, 1'b0, -1, 7'h7F, 7'h7F};
    vecs[0] = '{4'h1, 4'h8, 1'b1, 1'b1,  5, 7'h4F, 7'h00};
    vecs[1] = '{4'h2, 4'h8, 1'b1, 1'b1,  4, 7'h12, 7'h00};  // load inside SHOW0
    vecs[2] = '{4'h0, 4'hF, 1'b1, 1'b1, 19, 7'h01, 7'h38};  // load on the BLANK0-entry edge
    vecs[3] = '{4'h3, 4'h4, 1'b0, 1'b1, 10, 7'h7F, 7'h4C};
    vecs[4] = '{4'hA, 4'hB, 1'b1, 1'b0,  0, 7'h08, 7'h7F};
    vecs[5] = '{4'hC, 4'hD, 1'b1, 1'b1, 19, 7'h31, 7'h42};
    vecs[6] = '{4'hE, 4'h5, 1'b1, 1'b1, 13, 7'h30, 7'h24};
    vecs[7] = '{4'h6, 4'h7, 1'b1, 1'b1,  8, 7'h20, 7'h0F};
    vecs[8] = '{4'h9, 4'h0, 1'b1, 1'b1, 19, 7'h04, 7'h01};
    va      = '{4'h5, 4'h5, 1'b1, 1'b1, -1, 7'h24, 7'h24};
    vb      = '{4'h7, 4'h3, 1'b1, 1'b1, -1, 7'h0F, 7'h06};

    reset_n = 1'b0;
    digit0 = 4'h0; digit1 = 4'h0; en0 = 1'b0; en1 = 1'b0; load = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_a0", 0, {6'b0, a0}, 7'h01);
    chk("rst_a1", 0, {6'b0, a1}, 7'h01);
    chk("rst_cathode", 0, cathode, 7'h7F);
    chk("rst_frame_done", 0, {6'b0, frame_done}, 7'h00);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    cur = none;
    for (int i = 0; i < 9; i++) begin
      run_frame(cur, 20, vecs[i].load_pos, vecs[i], -1, none);
      cur = vecs[i];
    end

    // Two loads in one frame: the later one is what the next frame shows.
    run_frame(cur, 20, 3, va, 15, vb);
    cur = vb;
    run_frame(cur, 20, -1, none, -1, none);

    // Reset in SHOW1 with a shadow load pending: both shadow and active are cleared.
    run_frame(cur, 14, 5, va, -1, none);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_a0", 14, {6'b0, a0}, 7'h01);
    chk("midrst_a1", 14, {6'b0, a1}, 7'h01);
    chk("midrst_cathode", 14, cathode, 7'h7F);
    chk("midrst_frame_done", 14, {6'b0, frame_done}, 7'h00);
    reset_n = 1'b1;
    run_frame(none, 20, -1, none, -1, none);
    run_frame(none, 20, -1, none, -1, none);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
